// File: rtl/rv_pkg.sv
// Shared RV32I decode constants and LSU writeback types.
package rv_pkg;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MEM  = 2'd1,
    S_WB   = 2'd2
  } lsu_state_t;

  // What the single WB cycle reports: a register write, a fault pulse, or nothing.
  typedef enum logic [1:0] {
    RES_NONE     = 2'd0,
    RES_WRITE    = 2'd1,
    RES_MISALIGN = 2'd2,
    RES_BUSERR   = 2'd3
  } wb_kind_t;

  // Illegal width encodings are folded into the misaligned class.
  function automatic logic access_bad(input logic is_store, input logic [2:0] f3,
                                      input logic [1:0] off);
    logic bad;
    case (f3)
      F3_B:    bad = 1'b0;
      F3_BU:   bad = is_store;
      F3_H:    bad = off[0];
      F3_HU:   bad = is_store | off[0];
      F3_W:    bad = (off != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/load_extend.sv
// Selects the addressed byte/half/word of a read word and sign- or zero-extends it.
module load_extend
  import rv_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  input  logic [31:0] rdata,
  output logic [31:0] data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  assign byte_v = rdata[{off, 3'b000} +: 8];
  assign half_v = rdata[{off[1], 4'b0000} +: 16];

  always_comb begin
    case (funct3)
      F3_B:    data = {{24{byte_v[7]}}, byte_v};
      F3_BU:   data = {24'h0, byte_v};
      F3_H:    data = {{16{half_v[15]}}, half_v};
      F3_HU:   data = {16'h0, half_v};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/lsu_writeback.sv
// Execute-stage back end: ALU results go straight to writeback, loads/stores run
// one request/acknowledge memory transaction with a bounded wait.
module lsu_writeback
  import rv_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        IN_VALID,
  output logic        IN_READY,
  input  logic [6:0]  OPCODE,
  input  logic [2:0]  FUNCT3,
  input  logic [4:0]  RD,
  input  logic [31:0] ALU_RESULT,
  input  logic [31:0] STORE_DATA,
  output logic        MEM_REQ,
  output logic        MEM_WE,
  output logic [31:0] MEM_ADDR,
  output logic [31:0] MEM_WDATA,
  output logic [3:0]  MEM_WSTRB,
  input  logic        MEM_ACK,
  input  logic [31:0] MEM_RDATA,
  output logic        WB_EN,
  output logic [4:0]  WB_RD,
  output logic [31:0] WB_DATA,
  output logic        MISALIGN,
  output logic        BUS_ERR
);

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  lsu_state_t  state, state_nxt;
  wb_kind_t    kind_q, kind_nxt;
  logic        ready_q;
  logic [15:0] tmo_cnt;

  logic        accept, in_alu, in_mem, in_store, in_bad, tmo_hit;
  logic        is_store_q;
  logic [2:0]  funct3_q;
  logic [4:0]  rd_q;
  logic [31:0] addr_q, sdata_q, wb_data_q;
  logic [31:0] load_data, lane_wdata;
  logic [3:0]  lane_wstrb;
  logic        mem_active, wb_write;

  // ready_q keeps IN_READY low while reset is held and until the first edge after it.
  assign IN_READY = ready_q && (state == S_IDLE);
  assign accept   = IN_VALID && IN_READY;

  assign in_alu   = (OPCODE == OPC_OP) || (OPCODE == OPC_OPIMM) ||
                    (OPCODE == OPC_LUI) || (OPCODE == OPC_AUIPC);
  assign in_store = (OPCODE == OPC_STORE);
  assign in_mem   = in_store || (OPCODE == OPC_LOAD);
  assign in_bad   = access_bad(in_store, FUNCT3, ALU_RESULT[1:0]);
  assign tmo_hit  = (tmo_cnt == TMO_LAST);

  always_comb begin
    state_nxt = state;
    kind_nxt  = kind_q;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (in_alu) begin
            state_nxt = S_WB;
            kind_nxt  = RES_WRITE;
          end else if (in_mem && in_bad) begin
            state_nxt = S_WB;
            kind_nxt  = RES_MISALIGN;
          end else if (in_mem) begin
            state_nxt = S_MEM;
          end else begin
            state_nxt = S_WB;
            kind_nxt  = RES_NONE;
          end
        end
      end
      S_MEM: begin
        // An acknowledge on the limit cycle wins over the timeout.
        if (MEM_ACK) begin
          if (is_store_q) begin
            state_nxt = S_IDLE;
          end else begin
            state_nxt = S_WB;
            kind_nxt  = RES_WRITE;
          end
        end else if (tmo_hit) begin
          state_nxt = S_WB;
          kind_nxt  = RES_BUSERR;
        end
      end
      S_WB:    state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= S_IDLE;
      kind_q  <= RES_NONE;
      ready_q <= 1'b0;
      tmo_cnt <= '0;
    end else begin
      state   <= state_nxt;
      kind_q  <= kind_nxt;
      ready_q <= 1'b1;
      if (state != S_MEM) begin
        tmo_cnt <= '0;
      end else if (!MEM_ACK) begin
        tmo_cnt <= tmo_cnt + 16'd1;
      end
    end
  end

  // Operand capture: data registers carry no reset, outputs are gated by state.
  always_ff @(posedge CLK) begin
    if (accept) begin
      is_store_q <= in_store;
      funct3_q   <= FUNCT3;
      rd_q       <= RD;
      addr_q     <= ALU_RESULT;
      sdata_q    <= STORE_DATA;
      wb_data_q  <= ALU_RESULT;
    end
    if ((state == S_MEM) && MEM_ACK) begin
      wb_data_q <= load_data;
    end
  end

  load_extend u_load_extend (
    .off    (addr_q[1:0]),
    .funct3 (funct3_q),
    .rdata  (MEM_RDATA),
    .data   (load_data)
  );

  always_comb begin
    lane_wstrb = 4'b1111;
    lane_wdata = sdata_q;
    case (funct3_q[1:0])
      2'b00: begin
        lane_wstrb = 4'b0001 << addr_q[1:0];
        lane_wdata = {4{sdata_q[7:0]}};
      end
      2'b01: begin
        lane_wstrb = 4'b0011 << addr_q[1:0];
        lane_wdata = {2{sdata_q[15:0]}};
      end
      default: ;
    endcase
  end

  assign mem_active = (state == S_MEM);
  assign MEM_REQ    = mem_active;
  assign MEM_WE     = mem_active && is_store_q;
  assign MEM_ADDR   = mem_active ? {addr_q[31:2], 2'b00} : 32'h0;
  assign MEM_WDATA  = MEM_WE ? lane_wdata : 32'h0;
  assign MEM_WSTRB  = MEM_WE ? lane_wstrb : 4'b0000;

  // Writes to x0 still pass through WB but never pulse the register file.
  assign wb_write = (state == S_WB) && (kind_q == RES_WRITE) && (rd_q != 5'd0);
  assign WB_EN    = wb_write;
  assign WB_RD    = wb_write ? rd_q : 5'd0;
  assign WB_DATA  = wb_write ? wb_data_q : 32'h0;
  assign MISALIGN = (state == S_WB) && (kind_q == RES_MISALIGN);
  assign BUS_ERR  = (state == S_WB) && (kind_q == RES_BUSERR);

endmodule

// File: tb/tb_lsu_writeback.sv
// Directed bench for lsu_writeback: a transaction-level model fills a per-cycle
// table of expected outputs that one compare process checks every cycle.
module tb_lsu_writeback;

  localparam int unsigned TMO = 4;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        IN_VALID = 1'b0;
  logic        IN_READY;
  logic [6:0]  OPCODE = '0;
  logic [2:0]  FUNCT3 = '0;
  logic [4:0]  RD = '0;
  logic [31:0] ALU_RESULT = '0;
  logic [31:0] STORE_DATA = '0;
  logic        MEM_REQ, MEM_WE;
  logic [31:0] MEM_ADDR, MEM_WDATA;
  logic [3:0]  MEM_WSTRB;
  logic        MEM_ACK = 1'b0;
  logic [31:0] MEM_RDATA = '0;
  logic        WB_EN;
  logic [4:0]  WB_RD;
  logic [31:0] WB_DATA;
  logic        MISALIGN, BUS_ERR;

  always #5 CLK = ~CLK;

  lsu_writeback #(.TIMEOUT_CYCLES(TMO)) dut (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .OPCODE(OPCODE), .FUNCT3(FUNCT3), .RD(RD), .ALU_RESULT(ALU_RESULT),
    .STORE_DATA(STORE_DATA), .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE),
    .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA), .MEM_WSTRB(MEM_WSTRB),
    .MEM_ACK(MEM_ACK), .MEM_RDATA(MEM_RDATA), .WB_EN(WB_EN), .WB_RD(WB_RD),
    .WB_DATA(WB_DATA), .MISALIGN(MISALIGN), .BUS_ERR(BUS_ERR)
  );

  typedef struct packed {
    logic        ready;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        mis;
    logic        err;
  } obs_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  bit   chk_en = 1'b0;
  obs_t exp_tab[int];

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check_vec(input string name, input logic [127:0] got, input logic [127:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: actual %h required %h", name, got, want);
    end
  endtask

  function automatic obs_t idle_obs();
    obs_t o;
    o = '0;
    o.ready = 1'b1;
    return o;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.ready = IN_READY;  o.req = MEM_REQ;    o.we = MEM_WE;
    o.addr = MEM_ADDR;   o.wdata = MEM_WDATA; o.wstrb = MEM_WSTRB;
    o.wb_en = WB_EN;     o.wb_rd = WB_RD;    o.wb_data = WB_DATA;
    o.mis = MISALIGN;    o.err = BUS_ERR;
    return o;
  endfunction

  // Spec-level model: access size in bytes is 1 << funct3[1:0].
  function automatic logic [3:0] strb_model(input logic [2:0] f3, input logic [1:0] off);
    int sz;
    sz = 1 << f3[1:0];
    return 4'(((32'h1 << sz) - 32'h1) << off);
  endfunction

  function automatic logic [31:0] wdata_model(input logic [2:0] f3, input logic [31:0] sd);
    int sz;
    sz = 1 << f3[1:0];
    if (sz == 1) return (sd & 32'hFF) * 32'h0101_0101;
    if (sz == 2) return (sd & 32'hFFFF) * 32'h0001_0001;
    return sd;
  endfunction

  function automatic logic [31:0] ext_model(input logic [2:0] f3, input logic [1:0] off,
                                            input logic [31:0] rdata);
    int bits;
    logic [31:0] v, mask;
    bits = 8 * (1 << f3[1:0]);
    if (bits >= 32) return rdata;
    mask = (32'h1 << bits) - 32'h1;
    v = (rdata >> (8 * int'(off))) & mask;
    if (!f3[2] && v[bits-1]) v = v | ~mask;
    return v;
  endfunction

  function automatic bit legal_model(input bit is_st, input logic [2:0] f3, input logic [31:0] addr);
    int sz;
    if (is_st ? (f3 > 3'd2) : !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b0;
    sz = 1 << f3[1:0];
    return (addr & 32'(sz - 1)) == 32'h0;
  endfunction

  always @(negedge CLK) begin
    if (chk_en) begin
      obs_t w, g;
      w = exp_tab.exists(cyc) ? exp_tab[cyc] : idle_obs();
      g = sample();
      if (!w.req) begin
        g.we = 1'b0; g.addr = '0; g.wdata = '0; g.wstrb = '0;
        w.we = 1'b0; w.addr = '0; w.wdata = '0; w.wstrb = '0;
      end
      if (!w.we) begin
        g.wdata = '0; w.wdata = '0;
      end
      if (!w.wb_en) begin
        g.wb_rd = '0; g.wb_data = '0; w.wb_rd = '0; w.wb_data = '0;
      end
      check_vec($sformatf("cycle%0d", cyc), 128'(g), 128'(w));
    end
  end

  // ack_after = 0 means never acknowledge; otherwise ACK in that request cycle.
  task automatic do_op(input logic [6:0] opc, input logic [2:0] f3, input logic [4:0] rd,
                       input logic [31:0] alu, input logic [31:0] sd,
                       input int ack_after, input logic [31:0] rdata);
    int   k, m;
    bit   is_ld, is_st, runs_mem;
    obs_t e;
    k = cyc + 1;
    is_ld = (opc == 7'b0000011);
    is_st = (opc == 7'b0100011);
    runs_mem = 1'b0;
    m = (ack_after == 0) ? int'(TMO) : ack_after;
    e = '0;
    if (opc inside {7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111}) begin
      e.wb_en = (rd != 5'd0); e.wb_rd = rd; e.wb_data = alu;
      exp_tab[k] = e;
    end else if (is_ld || is_st) begin
      if (!legal_model(is_st, f3, alu)) begin
        e.mis = 1'b1;
        exp_tab[k] = e;
      end else begin
        runs_mem = 1'b1;
        for (int i = 0; i < m; i++) begin
          e = '0;
          e.req = 1'b1; e.we = is_st; e.addr = alu & ~32'h3;
          e.wstrb = is_st ? strb_model(f3, alu[1:0]) : 4'b0000;
          e.wdata = is_st ? wdata_model(f3, sd) : 32'h0;
          exp_tab[k + i] = e;
        end
        e = '0;
        if (ack_after == 0) begin
          e.err = 1'b1;
          exp_tab[k + m] = e;
        end else if (is_ld) begin
          e.wb_en = (rd != 5'd0); e.wb_rd = rd; e.wb_data = ext_model(f3, alu[1:0], rdata);
          exp_tab[k + m] = e;
        end
      end
    end else begin
      exp_tab[k] = e;
    end
    IN_VALID = 1'b1; OPCODE = opc; FUNCT3 = f3; RD = rd; ALU_RESULT = alu; STORE_DATA = sd;
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    OPCODE = 7'($urandom); FUNCT3 = 3'($urandom); RD = 5'($urandom);
    ALU_RESULT = $urandom; STORE_DATA = $urandom;
    if (runs_mem) begin
      if (ack_after > 0) begin
        repeat (ack_after - 1) @(posedge CLK);
        #1;
        MEM_ACK = 1'b1; MEM_RDATA = rdata;
        @(posedge CLK); #1;
        MEM_ACK = 1'b0; MEM_RDATA = $urandom;
      end else begin
        repeat (TMO) @(posedge CLK);
      end
    end
    repeat (2) @(posedge CLK);
    #1;
  endtask

  initial begin
    // Hand-computed values that pin the model itself.
    check_vec("pin_lb",   128'(ext_model(3'b000, 2'd3, 32'h80AA_BBCC)), 128'(32'hFFFF_FF80));
    check_vec("pin_lbu",  128'(ext_model(3'b100, 2'd3, 32'h80AA_BBCC)), 128'(32'h0000_0080));
    check_vec("pin_lh",   128'(ext_model(3'b001, 2'd2, 32'h8001_0000)), 128'(32'hFFFF_8001));
    check_vec("pin_sh_s", 128'(strb_model(3'b001, 2'd2)), 128'(4'b1100));
    check_vec("pin_sh_d", 128'(wdata_model(3'b001, 32'h1234_ABCD)), 128'(32'hABCD_ABCD));
    check_vec("pin_sb_s", 128'(strb_model(3'b000, 2'd3)), 128'(4'b1000));

    #2;
    check_vec("reset_async", 128'(sample()), 128'(0));
    repeat (2) @(posedge CLK);
    #1;
    check_vec("reset_held", 128'(sample()), 128'(0));
    RST = 1'b0;
    #1;
    check_vec("ready_before_edge", 128'(IN_READY), 128'(1'b0));
    @(posedge CLK); #1;
    check_vec("ready_after_edge", 128'(IN_READY), 128'(1'b1));
    chk_en = 1'b1;

    do_op(7'b0010011, 3'b000, 5'd5,  32'h0000_1234, 32'h0, 0, 32'h0);          // ADDI
    do_op(7'b0000011, 3'b000, 5'd7,  32'h0000_0103, 32'h0, 3, 32'h80AA_BBCC);  // LB
    do_op(7'b0000011, 3'b100, 5'd7,  32'h0000_0103, 32'h0, 3, 32'h80AA_BBCC);  // LBU
    do_op(7'b0100011, 3'b001, 5'd9,  32'h0000_0202, 32'h1234_ABCD, 2, 32'h0);  // SH
    do_op(7'b0000011, 3'b010, 5'd4,  32'h0000_0006, 32'h0, 1, 32'h0);          // LW misaligned
    do_op(7'b0000011, 3'b010, 5'd0,  32'h0000_0040, 32'h0, 1, 32'hDEAD_BEEF);  // LW to x0
    do_op(7'b0000011, 3'b010, 5'd6,  32'h0000_0080, 32'h0, 0, 32'h0);          // LW timeout
    do_op(7'b0000011, 3'b010, 5'd6,  32'h0000_0084, 32'h0, 4, 32'hCAFE_F00D);  // ACK on limit
    do_op(7'b0000011, 3'b001, 5'd8,  32'h0000_0102, 32'h0, 1, 32'h8001_0000);  // LH
    do_op(7'b0000011, 3'b101, 5'd8,  32'h0000_0101, 32'h0, 1, 32'h0);          // LHU misaligned
    do_op(7'b0000011, 3'b101, 5'd8,  32'h0000_0100, 32'h0, 2, 32'h1234_9ABC);  // LHU
    do_op(7'b0100011, 3'b000, 5'd1,  32'h0000_0003, 32'h0000_00A5, 1, 32'h0);  // SB
    do_op(7'b0100011, 3'b010, 5'd1,  32'h0000_0010, 32'h0BAD_F00D, 2, 32'h0);  // SW
    do_op(7'b0000011, 3'b011, 5'd2,  32'h0000_0000, 32'h0, 1, 32'h0);          // illegal load f3
    do_op(7'b0100011, 3'b100, 5'd2,  32'h0000_0000, 32'h0, 1, 32'h0);          // illegal store f3
    do_op(7'b0110111, 3'b000, 5'd31, 32'hABCD_E000, 32'h0, 0, 32'h0);          // LUI
    do_op(7'b0010111, 3'b000, 5'd3,  32'h8000_0010, 32'h0, 0, 32'h0);          // AUIPC
    do_op(7'b0110011, 3'b000, 5'd0,  32'h0000_0077, 32'h0, 0, 32'h0);          // OP to x0
    do_op(7'b1100011, 3'b000, 5'd3,  32'h0000_0044, 32'h0, 0, 32'h0);          // branch dropped

    MEM_ACK = 1'b1; MEM_RDATA = 32'hFFFF_FFFF;   // stray acknowledge while idle
    @(posedge CLK); #1;
    MEM_ACK = 1'b0;
    repeat (2) @(posedge CLK);
    #1;

    // Reset in the middle of a pending load.
    chk_en = 1'b0;
    IN_VALID = 1'b1; OPCODE = 7'b0000011; FUNCT3 = 3'b010; RD = 5'd3; ALU_RESULT = 32'h80;
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    @(posedge CLK); #1;
    check_vec("req_before_rst", 128'(MEM_REQ), 128'(1'b1));
    #2 RST = 1'b1;
    #1;
    check_vec("req_drop_async", 128'(MEM_REQ), 128'(1'b0));
    check_vec("outputs_in_rst", 128'(sample()), 128'(0));
    MEM_ACK = 1'b1; MEM_RDATA = 32'h1111_2222;
    @(posedge CLK); #1;
    MEM_ACK = 1'b0;
    check_vec("outputs_rst_edge", 128'(sample()), 128'(0));
    RST = 1'b0;
    #1;
    check_vec("ready_low_post_rst", 128'(IN_READY), 128'(1'b0));
    @(posedge CLK); #1;
    check_vec("idle_after_rst", 128'(sample()), 128'(idle_obs()));
    @(posedge CLK); #1;
    check_vec("no_wb_after_rst", 128'(sample()), 128'(idle_obs()));
    chk_en = 1'b1;
    do_op(7'b0010011, 3'b000, 5'd12, 32'h0000_5555, 32'h0, 0, 32'h0);

    repeat (2) @(posedge CLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lsu_writeback.md
Name: lsu_writeback

Overview:
- Back end of the execute stage: consumes the ALU result and the operands the operand selector produced.
- Routes OP / OP-IMM / LUI / AUIPC results straight to register-file writeback.
- For LOAD / STORE, treats the ALU result as the effective address and runs a request/acknowledge data-memory transaction. Loads are sign- or zero-extended by FUNCT3.
- Sits between the ALU and the register file and memory port. Single outstanding operation.

Parameters:
TIMEOUT_CYCLES, 255, max cycles MEM_REQ waits for MEM_ACK before abort (1..65535)

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous, active-high reset
IN_VALID  in  1  operation offered by ALU stage
IN_READY  out  1  block can accept an operation
OPCODE  in  7  RV32I major opcode
FUNCT3  in  3  width/sign selector
RD  in  5  destination register
ALU_RESULT  in  32  result, or effective address for LOAD/STORE
STORE_DATA  in  32  RS2 value for stores
MEM_REQ  out  1  memory request, held until ACK
MEM_WE  out  1  1 = write
MEM_ADDR  out  32  word-aligned address {addr[31:2],2'b00}
MEM_WDATA  out  32  lane-replicated store data
MEM_WSTRB  out  4  byte enables (0 on reads)
MEM_ACK  in  1  request complete; MEM_RDATA valid this cycle
MEM_RDATA  in  32  read word
WB_EN  out  1  one-cycle register write pulse
WB_RD  out  5  write register index
WB_DATA  out  32  write data
MISALIGN  out  1  one-cycle pulse, misaligned access dropped
BUS_ERR  out  1  one-cycle pulse, timeout abort

Behaviour:
- Reset: one clock `CLK`; reset `RST` is asynchronous and active-high.
  - While RST is high, state = IDLE and every output is 0, except IN_READY = 0.
  - IN_READY = 1 from the first edge after RST deasserts.
  - Reset mid-transaction drops MEM_REQ immediately and performs no writeback.
- States: IDLE, MEM, WB.
- Handshake:
  - IN_READY = (state == IDLE).
  - An operation is accepted on a rising edge with IN_VALID & IN_READY.
  - On acceptance, OPCODE/FUNCT3/RD/ALU_RESULT/STORE_DATA are latched.
- OP (0110011), OP-IMM (0010011), LUI (0110111), AUIPC (0010111):
  - IDLE -> WB.
  - WB_EN = 1 for the next cycle with WB_DATA = ALU_RESULT, then return to IDLE.
  - Latency is 1 cycle.
  - Throughput is one operation per 2 cycles.
- LOAD (0000011) and STORE (0100011), aligned:
  - IDLE -> MEM. MEM_REQ is high from the cycle after acceptance until and including the MEM_ACK cycle.
  - MEM_ADDR, MEM_WE, MEM_WDATA and MEM_WSTRB are stable while MEM_REQ is high.
  - Store on ACK: -> IDLE, no writeback.
  - Load on ACK: capture the extended data, then -> WB. WB_EN is high the cycle after ACK.
- Byte offset off = addr[1:0].
  - LB/LBU (000/100): byte MEM_RDATA[8*off+:8], sign- or zero-extended.
  - LH/LHU (001/101): half MEM_RDATA[16*off[1]+:16], sign- or zero-extended.
  - LW (010): whole word.
  - SB: WSTRB = 0001 << off, WDATA = {4{byte}}.
  - SH: WSTRB = 0011 << off, WDATA = {2{half}}.
  - SW: WSTRB = 1111.
- Misaligned:
  - Halfword with addr[0] = 1, or word with addr[1:0] != 0, is misaligned.
  - Result: no MEM_REQ, a MISALIGN pulse the cycle after acceptance, -> IDLE.
- Illegal FUNCT3:
  - Loads 011/110/111 and stores 011..111 are handled like misaligned: MISALIGN pulse, no access.
- Writes to x0:
  - If RD == 0, the WB state is still traversed but WB_EN stays 0.
- Timeout:
  - A 16-bit counter clears on entry to MEM and increments each MEM cycle without ACK.
  - When the count reaches TIMEOUT_CYCLES without ACK, drop MEM_REQ, pulse BUS_ERR the following cycle, -> IDLE, no writeback.
  - ACK in the same cycle as the limit takes priority over the timeout.
- Other opcodes (branch, JAL, JALR, SYSTEM, unknown):
  - Accepted and dropped: no outputs, -> IDLE after 1 cycle.
- Stray inputs:
  - MEM_ACK outside the MEM state is ignored.

Decomposition:
- Shared package `rv_pkg`:
  - Opcode constants: OPC_OP, OPC_OPIMM, OPC_LOAD, OPC_STORE, OPC_LUI, OPC_AUIPC.
  - FUNCT3 width constants: F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - State enum `lsu_state_t`.
- One combinational sub-module `load_extend` (off, funct3, rdata -> 32-bit extended value), reusable by a future cache path.
- Store lane and strobe generation stays inline.

Test Plan:
- ADDI result 0x0000_1234, RD=5 -> WB_EN pulse 1 cycle after accept, WB_RD=5, WB_DATA=0x1234; IN_READY low for exactly 1 cycle.
- LB at addr 0x103, ACK after 3 cycles with RDATA=0x80AA_BBCC:
  - MEM_ADDR=0x100, WSTRB=0, MEM_REQ high for 3 cycles.
  - WB_DATA=0xFFFF_FF80.
  - The same access as LBU -> WB_DATA=0x0000_0080.
- SH at addr 0x202, STORE_DATA=0x1234_ABCD -> MEM_WE=1, WSTRB=1100, WDATA=0xABCD_ABCD; no WB_EN; IN_READY returns the cycle after ACK.
- LW at addr 0x006 -> no MEM_REQ, MISALIGN pulse 1 cycle after accept.
- LW to RD=0 with ACK -> transaction completes with WB_EN held 0.
- TIMEOUT_CYCLES=4:
  - LW with no ACK -> MEM_REQ high 4 cycles, then BUS_ERR pulse, no WB.
  - Separately, assert RST during MEM -> MEM_REQ falls combinationally and all outputs read 0.
